// File: rtl/updown_seq_ctrl.sv
// ---------------------------------------------------------------------------
// updown_seq_ctrl
// Sequencer for the 4-bit up/down counter and its 7-seg direction display.
// START/STOP buttons drive an IDLE/RUN/HOLD state machine. While running, a
// prescaler emits a one-cycle count enable every TICK_DIV clocks. Direction
// comes from DIR_SW in wrap mode (MODE=0). In bounce mode (MODE=1) it
// reverses at HI_LIM/LO_LIM, on the same edge as that tick's step.
// ---------------------------------------------------------------------------
module updown_seq_ctrl #(
    parameter int unsigned      TICK_DIV = 50_000_000,
    parameter int unsigned      CNT_W    = 4,
    parameter logic [CNT_W-1:0] HI_LIM   = CNT_W'(15),
    parameter logic [CNT_W-1:0] LO_LIM   = CNT_W'(0)
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             START,
    input  logic             STOP,
    input  logic             DIR_SW,
    input  logic             MODE,
    input  logic [CNT_W-1:0] Q_IN,
    output logic             CNT_EN,
    output logic             UP,
    output logic [6:0]       Seg,
    output logic             BUSY
);

    // Prescaler width and terminal count (TICK_DIV >= 2 keeps PW >= 1)
    localparam int unsigned     PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]   PRESC_ONE = PW'(1);
    localparam logic [PW-1:0]   PRESC_ZERO = PW'(0);

    // FSM encoding; the unused code 2'd3 recovers to IDLE
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    // Active-low segment patterns {a..g}
    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [6:0] SEG_UP  = 7'b0111110;
    localparam logic [6:0] SEG_DN  = 7'b0111101;

    // Display pattern for a given state and direction; blank outside RUN/HOLD
    function automatic logic [6:0] seg_pattern(input logic [1:0] st, input logic up);
        logic [6:0] pat;
        case (st)
            ST_RUN, ST_HOLD: pat = up ? SEG_UP : SEG_DN;
            default:         pat = SEG_OFF;
        endcase
        return pat;
    endfunction

    // Bounce-mode direction: reverse when the step would leave the limits
    function automatic logic bounce_dir(input logic up, input logic [CNT_W-1:0] q);
        logic d;
        if (up && (q == HI_LIM)) begin
            d = 1'b0;
        end else if (!up && (q == LO_LIM)) begin
            d = 1'b1;
        end else begin
            d = up;
        end
        return d;
    endfunction

    // Synchronizer and edge-detect registers
    logic start_meta_r, start_sync_r, start_prev_r;
    logic stop_meta_r,  stop_sync_r,  stop_prev_r;
    logic dir_meta_r,   dir_sync_r;

    // Control state
    logic [1:0]    state_r;
    logic [PW-1:0] presc_r;
    logic          cnt_en_r;
    logic          up_r;
    logic [6:0]    seg_r;
    logic          busy_r;

    // Combinational next values
    logic          start_pulse_s;
    logic          stop_pulse_s;
    logic          tick_s;
    logic          tick_dir_s;
    logic [1:0]    state_nxt_s;
    logic [PW-1:0] presc_nxt_s;
    logic          up_nxt_s;

    // Two-flop synchronizers plus a delayed copy for rising-edge detection
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            start_meta_r <= 1'b0;
            start_sync_r <= 1'b0;
            start_prev_r <= 1'b0;
            stop_meta_r  <= 1'b0;
            stop_sync_r  <= 1'b0;
            stop_prev_r  <= 1'b0;
            dir_meta_r   <= 1'b0;
            dir_sync_r   <= 1'b0;
        end else begin
            start_meta_r <= START;
            start_sync_r <= start_meta_r;
            start_prev_r <= start_sync_r;
            stop_meta_r  <= STOP;
            stop_sync_r  <= stop_meta_r;
            stop_prev_r  <= stop_sync_r;
            dir_meta_r   <= DIR_SW;
            dir_sync_r   <= dir_meta_r;
        end
    end

    // One-cycle button pulses taken from the synchronized rising edges
    always_comb begin
        start_pulse_s = start_sync_r & ~start_prev_r;
        stop_pulse_s  = stop_sync_r  & ~stop_prev_r;
    end

    // Direction to load on a tick, chosen by MODE at the wrap cycle
    always_comb begin
        if (MODE) begin
            tick_dir_s = bounce_dir(up_r, Q_IN);
        end else begin
            tick_dir_s = dir_sync_r;
        end
    end

    // Next state, prescaler and direction; STOP beats a simultaneous START
    always_comb begin
        state_nxt_s = state_r;
        presc_nxt_s = presc_r;
        up_nxt_s    = up_r;
        tick_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_pulse_s && !stop_pulse_s) begin
                    state_nxt_s = ST_RUN;
                    presc_nxt_s = PRESC_ZERO;
                    up_nxt_s    = MODE ? 1'b1 : dir_sync_r;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // The prescaler advances on every RUN cycle, including the
                // cycle whose STOP pulse moves the FSM into HOLD.
                if (presc_r == PRESC_MAX) begin
                    presc_nxt_s = PRESC_ZERO;
                    tick_s      = 1'b1;
                    up_nxt_s    = tick_dir_s;
                end else begin
                    presc_nxt_s = presc_r + PRESC_ONE;
                end
                if (stop_pulse_s) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_HOLD: begin
                if (stop_pulse_s) begin
                    state_nxt_s = ST_IDLE;
                    presc_nxt_s = PRESC_ZERO;
                end else if (start_pulse_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                presc_nxt_s = PRESC_ZERO;
                up_nxt_s    = 1'b1;
            end
        endcase
    end

    // FSM, prescaler and direction registers with BUSY tracking the new state
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_r  <= ST_IDLE;
            presc_r  <= PRESC_ZERO;
            cnt_en_r <= 1'b0;
            up_r     <= 1'b1;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            presc_r  <= presc_nxt_s;
            cnt_en_r <= tick_s;
            up_r     <= up_nxt_s;
            busy_r   <= (state_nxt_s == ST_RUN);
        end
    end

    // Display register trails the state/direction registers by one cycle
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            seg_r <= SEG_OFF;
        end else begin
            seg_r <= seg_pattern(state_r, up_r);
        end
    end

    assign CNT_EN = cnt_en_r;
    assign UP     = up_r;
    assign Seg    = seg_r;
    assign BUSY   = busy_r;

endmodule

// File: tb/tb_updown_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_updown_seq_ctrl
// Directed scenarios followed by randomized button/switch activity. A
// behavioural model (integer phase counter, pin-sample history, own counter)
// predicts every output each cycle; a counter driven by the DUT's CNT_EN/UP
// feeds Q_IN back and is compared against the model's counter.
// ---------------------------------------------------------------------------
module tb_updown_seq_ctrl;

    localparam int TD = 4;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HOLD = 2;
    localparam logic [3:0] HI = 4'd15;
    localparam logic [3:0] LO = 4'd0;

    logic       CLK    = 1'b0;
    logic       RSTn   = 1'b1;
    logic       START  = 1'b0;
    logic       STOP   = 1'b0;
    logic       DIR_SW = 1'b1;
    logic       MODE   = 1'b0;
    logic [3:0] q      = 4'd0;
    logic       CNT_EN;
    logic       UP;
    logic [6:0] Seg;
    logic       BUSY;

    logic       load_req = 1'b0;
    logic [3:0] load_val = 4'd0;

    int n_total = 0;
    int n_bad   = 0;

    updown_seq_ctrl #(
        .TICK_DIV (TD),
        .CNT_W    (4),
        .HI_LIM   (HI),
        .LO_LIM   (LO)
    ) dut (
        .CLK    (CLK),
        .RSTn   (RSTn),
        .START  (START),
        .STOP   (STOP),
        .DIR_SW (DIR_SW),
        .MODE   (MODE),
        .Q_IN   (q),
        .CNT_EN (CNT_EN),
        .UP     (UP),
        .Seg    (Seg),
        .BUSY   (BUSY)
    );

    always #5 CLK = ~CLK;

    // Counter datapath stand-in, stepped by the DUT's own enable/direction
    always @(posedge CLK) begin
        if (load_req) q <= load_val;
        else if (CNT_EN) q <= UP ? q + 4'd1 : q - 4'd1;
    end

    // Reference model state
    int         m_state = M_IDLE;
    int         m_phase = 0;
    int         m_state_n;
    logic       m_cnt_en = 1'b0;
    logic       m_up = 1'b1;
    logic       m_busy = 1'b0;
    logic [6:0] m_seg = 7'b1111111;
    logic [3:0] m_q = 4'd0;
    logic [2:0] sh = 3'b000;   // START samples, [0] newest
    logic [2:0] ph = 3'b000;   // STOP samples, [0] newest
    logic [1:0] dh = 2'b00;    // DIR_SW samples, [0] newest
    logic       st_rise, sp_rise, fire, up_n;

    // Behavioural prediction of all outputs after each clock edge
    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            m_state  = M_IDLE;
            m_phase  = 0;
            m_cnt_en = 1'b0;
            m_up     = 1'b1;
            m_busy   = 1'b0;
            m_seg    = 7'b1111111;
            sh       = 3'b000;
            ph       = 3'b000;
            dh       = 2'b00;
        end else begin
            // A pin edge is acted on once it has been seen in two samples
            st_rise = sh[1] && !sh[2];
            sp_rise = ph[1] && !ph[2];
            m_seg   = (m_state == M_IDLE) ? 7'b1111111 :
                      (m_up ? 7'b0111110 : 7'b0111101);
            fire    = (m_state == M_RUN) && (m_phase == TD - 1);
            up_n    = m_up;
            if (fire) begin
                if (!MODE)                    up_n = dh[1];
                else if (m_up && m_q == HI)   up_n = 1'b0;
                else if (!m_up && m_q == LO)  up_n = 1'b1;
            end
            m_state_n = m_state;
            if (m_state == M_IDLE) begin
                if (st_rise && !sp_rise) begin
                    m_state_n = M_RUN;
                    m_phase   = 0;
                    up_n      = MODE ? 1'b1 : dh[1];
                end
            end else if (m_state == M_RUN) begin
                m_phase = (m_phase + 1) % TD;
                if (sp_rise) m_state_n = M_HOLD;
            end else begin
                if (sp_rise) begin
                    m_state_n = M_IDLE;
                    m_phase   = 0;
                end else if (st_rise) begin
                    m_state_n = M_RUN;
                end
            end
            if (load_req)      m_q = load_val;
            else if (m_cnt_en) m_q = m_up ? m_q + 4'd1 : m_q - 4'd1;
            m_cnt_en = fire;
            m_up     = up_n;
            m_state  = m_state_n;
            m_busy   = (m_state_n == M_RUN);
            sh = {sh[1:0], START};
            ph = {ph[1:0], STOP};
            dh = {dh[0], DIR_SW};
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Compare on the falling edge, well away from the active edge
    always @(negedge CLK) begin
        if (!RSTn) begin
            check_eq("rst_cnt_en", {31'd0, CNT_EN}, 32'd0);
            check_eq("rst_up",     {31'd0, UP},     32'd1);
            check_eq("rst_seg",    {25'd0, Seg},    32'h7F);
            check_eq("rst_busy",   {31'd0, BUSY},   32'd0);
        end else begin
            check_eq("cnt_en", {31'd0, CNT_EN}, {31'd0, m_cnt_en});
            check_eq("up",     {31'd0, UP},     {31'd0, m_up});
            check_eq("seg",    {25'd0, Seg},    {25'd0, m_seg});
            check_eq("busy",   {31'd0, BUSY},   {31'd0, m_busy});
            check_eq("q",      {28'd0, q},      {28'd0, m_q});
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic press_start();
        START = 1'b1; cyc(3); START = 1'b0; cyc(2);
    endtask

    task automatic press_stop();
        STOP = 1'b1; cyc(3); STOP = 1'b0; cyc(2);
    endtask

    initial begin
        #2 RSTn = 1'b0;
        cyc(3);
        RSTn = 1'b1;
        cyc(2);

        // Wrap mode counting up through a full 0..15..0 cycle
        MODE = 1'b0; DIR_SW = 1'b1;
        START = 1'b1; cyc(3); START = 1'b0;
        cyc(72);

        // Hold, resume, then stop back to IDLE
        press_stop();  cyc(6);
        press_start(); cyc(9);
        press_stop();  cyc(3);
        press_stop();  cyc(4);

        // Bounce mode starting from 13: through 15 down to 0 and back up
        load_val = 4'd13; load_req = 1'b1; cyc(1); load_req = 1'b0;
        MODE = 1'b1;
        press_start();
        cyc(90);

        // START and STOP together while running: STOP wins
        START = 1'b1; STOP = 1'b1; cyc(4);
        START = 1'b0; STOP = 1'b0; cyc(6);
        press_start(); cyc(5);

        // Direction switch flipped mid-interval in wrap mode
        MODE = 1'b0; DIR_SW = 1'b1; cyc(6);
        DIR_SW = 1'b0; cyc(12);
        DIR_SW = 1'b1; cyc(1);

        // Reset while running
        RSTn = 1'b0; cyc(2); RSTn = 1'b1; cyc(3);

        // Randomized button, switch and mode activity with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 11) == 0) START  = ~START;
            if ($urandom_range(0, 17) == 0) STOP   = ~STOP;
            if ($urandom_range(0, 9)  == 0) DIR_SW = ~DIR_SW;
            if ($urandom_range(0, 59) == 0) MODE   = ~MODE;
            if ($urandom_range(0, 699) == 0) begin
                RSTn = 1'b0; cyc(2); RSTn = 1'b1;
            end
            cyc(1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
